// File: rtl/mod_dec_inv_mix_columns.sv
// AES InvMixColumns stage for the decoder: captures one 16-byte state and processes
// one column per cycle, writing each result column transposed (row r of column c at byte c+4r).
module mod_dec_inv_mix_columns #(
    parameter int N     = 16,
    parameter int NROWS = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [N-1:0][7:0]   inp_imC,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [N-1:0][7:0]   outp_imC,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int LASTCOL = N / NROWS - 1;

    state_t             r_state;
    state_t             w_nextState;
    logic [1:0]         r_col;
    logic [N-1:0][7:0]  r_capState;
    logic [N-1:0][7:0]  r_resState;
    logic [7:0]         w_colIn  [4];
    logic [7:0]         w_colOut [4];

    function automatic logic [7:0] f_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiplies by a 4-bit constant as a sum of a, 2a, 4a, 8a.
    function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = f_xtime(a);
        x4 = f_xtime(x2);
        x8 = f_xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
               (k[1] ? x2 : 8'h00) ^ (k[0] ? a  : 8'h00);
    endfunction

    always_comb begin
        w_colIn  = '{default: 8'h00};
        w_colOut = '{default: 8'h00};
        for (int r = 0; r < 4; r++) begin
            w_colIn[r] = r_capState[{r_col, 2'(r)}];
        end
        for (int r = 0; r < 4; r++) begin
            w_colOut[r] = f_gmul(w_colIn[r],          4'he) ^
                          f_gmul(w_colIn[2'(r + 1)],  4'hb) ^
                          f_gmul(w_colIn[2'(r + 2)],  4'hd) ^
                          f_gmul(w_colIn[2'(r + 3)],  4'h9);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_nextState = CALC;
            CALC:    if (r_col == 2'(LASTCOL)) w_nextState = DONE;
            DONE:    if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // The column counter wraps to 0 after column 3, but CALC always exits on that cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_col      <= 2'd0;
            r_capState <= '0;
            r_resState <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_capState <= inp_imC;
            r_col      <= 2'd0;
        end else if (r_state == CALC) begin
            for (int r = 0; r < 4; r++) begin
                r_resState[{2'(r), r_col}] <= w_colOut[r];
            end
            r_col <= r_col + 2'd1;
        end
    end

    assign outp_imC = r_resState;

endmodule

// File: tb/tb_mod_dec_inv_mix_columns.sv
// Self-checking bench for mod_dec_inv_mix_columns: known-answer table, back-pressure,
// mid-operation reset and a MixColumns round trip, all checked through a scoreboard queue.
module tb_mod_dec_inv_mix_columns;

    logic               clk;
    logic               resetn;
    logic [15:0][7:0]   inp_imC;
    logic               in_valid;
    logic               in_ready;
    logic [15:0][7:0]   outp_imC;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t         vecs [4];
    logic [127:0] sbq [$];
    int           nApplied = 0;
    int           nFail = 0;

    mod_dec_inv_mix_columns #(.N(16), .NROWS(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .inp_imC   (inp_imC),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .outp_imC  (outp_imC),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Shift-and-add GF(2^8) multiply, independent of the xtime chain in the design.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Encoder MixColumns: reads column c row r at byte c+4r, writes it at byte 4c+r.
    function automatic logic [127:0] encMix(input logic [127:0] xin);
        logic [15:0][7:0] x;
        logic [15:0][7:0] y;
        logic [7:0] a0, a1, a2, a3;
        x = xin;
        for (int c = 0; c < 4; c++) begin
            a0 = x[c]; a1 = x[c + 4]; a2 = x[c + 8]; a3 = x[c + 12];
            y[4*c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            y[4*c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            y[4*c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            y[4*c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return y;
    endfunction

    function automatic logic [127:0] mkIn(input logic [31:0] w0, w1, w2, w3);
        logic [15:0][7:0] s;
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[4*c + r] = w[c][31 - 8*r -: 8];
        return s;
    endfunction

    function automatic logic [127:0] mkOut(input logic [31:0] w0, w1, w2, w3);
        logic [15:0][7:0] s;
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[c + 4*r] = w[c][31 - 8*r -: 8];
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nApplied++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic waitOutValid(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "-latency"}, 128'(lat), 128'd4);
    endtask

    // Sends one state, then checks latency, result and the return to IDLE.
    task automatic applyStimulus(input logic [127:0] din, input logic [127:0] dexp, input string tag);
        int guard;
        int lat;
        inp_imC  = din;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        sbq.push_back(dexp);
        inp_imC = {$urandom, $urandom, $urandom, $urandom};
        waitOutValid(tag, lat);
        checkOutput({tag, "-data"}, outp_imC, sbq.pop_front());
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, "-release"}, 128'({out_valid, busy, in_ready}), 128'(3'b001));
    endtask

    initial begin
        logic [127:0] x;
        logic [127:0] bpExp;
        int lat;
        int sawValid;

        vecs[0] = '{mkIn(32'h8e4da1bc, 32'h0, 32'h0, 32'h0),
                    mkOut(32'hdb135345, 32'h0, 32'h0, 32'h0)};
        vecs[1] = '{mkIn(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6),
                    mkOut(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5)};
        vecs[2] = '{mkIn(32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff),
                    mkOut(32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff)};
        vecs[3] = '{mkIn(32'h0, 32'h0, 32'h0, 32'h0),
                    mkOut(32'h0, 32'h0, 32'h0, 32'h0)};

        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inp_imC   = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        checkOutput("reset-ctl", 128'({out_valid, busy, in_ready}), 128'(3'b001));
        checkOutput("reset-data", outp_imC, 128'd0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].din, vecs[i].dout, $sformatf("table%0d", i));
        end

        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("idle-outready", 128'({out_valid, busy, in_ready}), 128'(3'b001));

        $display("[TB] back-pressure sequence");
        inp_imC  = vecs[1].din;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sbq.push_back(vecs[1].dout);
        waitOutValid("bp", lat);
        bpExp = sbq.pop_front();
        checkOutput("bp-first", outp_imC, bpExp);
        inp_imC  = vecs[2].din;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("bp-ctl", 128'({out_valid, busy, in_ready}), 128'(3'b110));
            checkOutput("bp-data", outp_imC, bpExp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("bp-release", 128'({out_valid, busy, in_ready}), 128'(3'b001));
        checkOutput("bp-hold", outp_imC, bpExp);

        $display("[TB] reset during CALC");
        inp_imC  = vecs[1].din;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sbq.push_back(vecs[1].dout);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        sbq.delete();
        checkOutput("abort-ctl", 128'({out_valid, busy, in_ready}), 128'(3'b001));
        checkOutput("abort-data", outp_imC, 128'd0);
        sawValid = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) sawValid++;
        end
        checkOutput("abort-novalid", 128'(sawValid), 128'd0);
        applyStimulus(vecs[0].din, vecs[0].dout, "post-abort");

        $display("[TB] round trip");
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(encMix(x), x, "roundtrip");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nFail);
        $finish;
    end

endmodule

// File: doc/mod_dec_inv_mix_columns.md
MOD_DEC_INV_MIX_COLUMNS -- requirements
Module: mod_dec_inv_mix_columns

Interface
REQ-001 Parameter: N, default 16, number of state bytes (fixed at 16; other values unsupported).
REQ-002 Parameter: NROWS, default 4, bytes per column (fixed at 4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 inp_imC  input  [N-1:0][7:0]  state to invert; byte k is inp_imC[k]; column c = bytes 4c..4c+3 (row r at 4c+r).
REQ-006 in_valid  input  1  inp_imC valid this cycle.
REQ-007 in_ready  output  1  block can accept a state this cycle.
REQ-008 outp_imC  output  [N-1:0][7:0]  result; column c row r at byte c+4r.
REQ-009 out_valid  output  1  outp_imC holds a completed result not yet consumed.
REQ-010 out_ready  input  1  downstream accepts result this cycle.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 Block SHALL compute AES InvMixColumns per column: o0=0e*a0^0b*a1^0d*a2^09*a3; o1=09*a0^0e*a1^0b*a2^0d*a3; o2=0d*a0^09*a1^0e*a2^0b*a3; o3=0b*a0^0d*a1^09*a2^0e*a3, in GF(2^8) modulo 0x11b.
REQ-013 GF multiplies SHALL be built from xtime (shift left 1, XOR 8'h1b when bit 7 was set), truncated to 8 bits; no lookup tables.
REQ-014 Byte mapping SHALL make this block the exact inverse of the encoder MixColumns stage: feeding the encoder's output into inp_imC returns the encoder's original input on outp_imC.
REQ-015 FSM states: IDLE, CALC, DONE.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready, capture inp_imC into an internal 128-bit register, clear column counter col to 0, go to CALC.
REQ-017 CALC: in_ready=0; one column per cycle, column col written into result register bytes col, col+4, col+8, col+12; col increments; after col=3 is processed go to DONE.
REQ-018 col SHALL be 2 bits and SHALL NOT wrap into a fifth computation; the col=3 cycle always exits CALC.
REQ-019 DONE: out_valid=1, in_ready=0; on out_ready=1 return to IDLE; otherwise hold DONE with outp_imC stable.
REQ-020 Latency: input accepted at edge E; out_valid SHALL first be high after edge E+4; minimum throughput one state per 6 cycles (accept, 4x CALC, DONE+handshake).
REQ-021 outp_imC SHALL hold its last completed value after the output handshake until the next CALC overwrites it column by column; its value is only meaningful while out_valid=1.
REQ-022 in_valid while in_ready=0 SHALL be ignored (no capture, no error); upstream keeps in_valid and data stable until accepted.
REQ-023 inp_imC changes after acceptance SHALL not affect the result in progress.
REQ-024 out_ready while out_valid=0 SHALL have no effect.
REQ-025 busy = (state != IDLE).

Reset
REQ-026 On resetn=0 at a clock edge: state=IDLE, col=0, capture and result registers all zero.
REQ-027 Output values in reset: in_ready=1 once resetn=1, out_valid=0, busy=0, outp_imC=0.
REQ-028 Reset asserted mid-CALC or in DONE SHALL abort the operation; no out_valid is produced for the aborted state.
REQ-029 No asynchronous path from resetn to any flop.

Verification
REQ-030 FIPS-197 vector: column 0 = 8e 4d a1 bc (bytes 0..3), other columns zero -> after 4 CALC cycles out_valid=1, bytes 0,4,8,12 = db 13 53 45, all other bytes 00.
REQ-031 Four columns {8e4da1bc, 9fdc589d, 01010101, d5d5d7d6} -> columns {db135345, f20a225c, 01010101, d4d4d4d5} at bytes c+4r.
REQ-032 Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and outp_imC stable, in_ready=0, second in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-033 Reset at second CALC cycle -> next cycle IDLE, outp_imC=0, out_valid=0; new input afterwards completes correctly.
REQ-034 Round trip: 1000 random states through encoder MixColumns then this block -> output equals original input; each completion exactly 4 cycles after acceptance.
